// File: rtl/player_input_pkg.sv
// Shared constants for the player command path: frame/debounce defaults and button indices.
// Also used by player_move and the board top level.
package player_input_pkg;
  localparam int unsigned SCEN_DIV_DEF  = 833_333;
  localparam int unsigned DEBOUNCE_DEF  = 500_000;
  localparam int unsigned CNT_WIDTH_DEF = 20;
  localparam int          NUM_BTN       = 3;

  typedef enum logic [1:0] {
    BTN_LEFT  = 2'd0,
    BTN_RIGHT = 2'd1,
    BTN_JUMP  = 2'd2
  } btn_idx_e;
endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-FF synchroniser, counter-based debouncer holding a stable level,
// and a one-cycle pulse in the cycle right after the stable level goes 0 -> 1.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise
);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s1_q, s1_d;
  logic                 s2_q, s2_d;
  logic                 lvl_q, lvl_d;
  logic                 rise_q, rise_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d   = btn_raw;
    s2_d   = s1_q;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    cnt_d  = '0;
    // Counter only survives while the synchronised input keeps disagreeing with the level.
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d  = s2_q;
        rise_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;
endmodule

// File: rtl/player_input_ctrl.sv
// Per-player command generator: debounced buttons -> move_left/move_right/jump levels,
// plus the SCEN frame strobe that player_move uses to sample them.
module player_input_ctrl
  import player_input_pkg::*;
#(
  parameter int unsigned SCEN_DIV        = SCEN_DIV_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_jump,
  input  logic game_active,
  input  logic jump_active,
  output logic SCEN,
  output logic move_enable,
  output logic move_left,
  output logic move_right,
  output logic jump
);
  localparam logic [CNT_WIDTH-1:0] DIV_LAST = CNT_WIDTH'(SCEN_DIV - 1);

  logic [NUM_BTN-1:0]   btn_raw, lvl, rise;
  logic [CNT_WIDTH-1:0] div_q, div_d;
  logic                 scen;
  logic                 me_q, me_d;
  logic                 ml_q, ml_d;
  logic                 mr_q, mr_d;
  logic                 jp_q, jp_d;
  logic                 unused_rise;

  assign btn_raw[BTN_LEFT]  = btn_left;
  assign btn_raw[BTN_RIGHT] = btn_right;
  assign btn_raw[BTN_JUMP]  = btn_jump;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[g]),
      .level  (lvl[g]),
      .rise   (rise[g])
    );
  end

  // Only the jump button is edge-triggered; movement is level-driven.
  assign unused_rise = &{1'b0, rise[BTN_LEFT], rise[BTN_RIGHT]};

  assign scen = (div_q == DIV_LAST);

  always_comb begin
    div_d = scen ? '0 : div_q + 1'b1;
    me_d  = game_active;
    ml_d  = lvl[BTN_LEFT] & ~lvl[BTN_RIGHT] & game_active;
    mr_d  = lvl[BTN_RIGHT] & ~lvl[BTN_LEFT] & game_active;
    jp_d  = jp_q;
    if (scen && me_q) jp_d = 1'b0;
    // A new press overrides the consume in the same cycle, so it lands in the next frame.
    if (rise[BTN_JUMP] && game_active && !jump_active) jp_d = 1'b1;
    if (!game_active) jp_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      me_q  <= 1'b0;
      ml_q  <= 1'b0;
      mr_q  <= 1'b0;
      jp_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      me_q  <= me_d;
      ml_q  <= ml_d;
      mr_q  <= mr_d;
      jp_q  <= jp_d;
    end
  end

  assign SCEN        = scen;
  assign move_enable = me_q;
  assign move_left   = ml_q;
  assign move_right  = mr_q;
  assign jump        = jp_q;
endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl with SCEN_DIV=8, DEBOUNCE_CYCLES=4: directed scenarios with
// fixed expectations plus a long randomized run against a cycle-level behavioural model.
module tb_player_input_ctrl;
  localparam int DIV = 8;
  localparam int DC  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic game_active = 1'b0, jump_active = 1'b0;
  logic SCEN, move_enable, move_left, move_right, jump;
  logic [4:0] outs;

  int errors = 0;
  int checks = 0;

  // Model state: raw-sample delay line, last DC synchronised samples, stable levels, outputs.
  bit m_d1 [3];
  bit m_d2 [3];
  bit m_xh [3][DC];
  int m_xn [3];
  bit m_s [3];
  bit m_rise [3];
  int m_cyc = 0;
  bit m_me = 0, m_ml = 0, m_mr = 0, m_jp = 0;

  player_input_ctrl #(.SCEN_DIV(DIV), .DEBOUNCE_CYCLES(DC), .CNT_WIDTH(20)) dut (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .game_active(game_active), .jump_active(jump_active), .SCEN(SCEN), .move_enable(move_enable),
    .move_left(move_left), .move_right(move_right), .jump(jump)
  );

  always #5 clk = ~clk;
  assign outs = {SCEN, move_enable, move_left, move_right, jump};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [4:0] m_outs();
    return {((m_cyc % DIV) == DIV - 1), m_me, m_ml, m_mr, m_jp};
  endfunction

  // Advance model by one clock using the inputs currently driven, then step the DUT.
  task automatic tick();
    bit raw [3];
    bit old_s [3];
    bit old_rise [3];
    bit scen_now, x, flip;
    raw[0] = btn_left; raw[1] = btn_right; raw[2] = btn_jump;
    if (reset) begin
      for (int b = 0; b < 3; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_s[b] = 0; m_rise[b] = 0; m_xn[b] = 0;
      end
      m_cyc = 0; m_me = 0; m_ml = 0; m_mr = 0; m_jp = 0;
    end else begin
      scen_now = (m_cyc % DIV) == DIV - 1;
      old_s = m_s;
      old_rise = m_rise;
      for (int b = 0; b < 3; b++) begin
        x = m_d2[b];
        m_d2[b] = m_d1[b];
        m_d1[b] = raw[b];
        for (int i = DC - 1; i > 0; i--) m_xh[b][i] = m_xh[b][i-1];
        m_xh[b][0] = x;
        if (m_xn[b] < DC) m_xn[b]++;
        flip = (m_xn[b] == DC);
        for (int i = 0; i < DC; i++) if (m_xh[b][i] == m_s[b]) flip = 0;
        m_rise[b] = flip && !m_s[b];
        if (flip) m_s[b] = !m_s[b];
      end
      m_ml = old_s[0] && !old_s[1] && game_active;
      m_mr = old_s[1] && !old_s[0] && game_active;
      if (scen_now && m_me) m_jp = 0;
      if (old_rise[2] && game_active && !jump_active) m_jp = 1;
      if (!game_active) m_jp = 0;
      m_me = game_active;
      m_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < DIV && (m_cyc % DIV) != p; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; game_active = 1'b0;
    tick(); tick();
    checks++;
    if (outs !== 5'b0) begin errors++; $display("FAIL reset_outs got=%b exp=00000", outs); end
    reset = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      checks++;
      if (outs !== {(k % 8) == 7, 4'b0})
        begin errors++; $display("FAIL idle_scen k=%0d got=%b exp=%b", k, outs, {(k % 8) == 7, 4'b0}); end
      tick();
    end
  endtask

  task automatic test_left();
    game_active = 1'b1;
    repeat (3) tick();
    btn_left = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if ({move_left, move_right} !== {t >= 7, 1'b0})
        begin errors++; $display("FAIL left_hold t=%0d got=%b%b exp=%b0", t, move_left, move_right, t >= 7); end
    end
    btn_left = 1'b0;
    repeat (10) tick();
    btn_left = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (t == 3) btn_left = 1'b0;
      checks++;
      if (move_left !== 1'b0) begin errors++; $display("FAIL left_glitch t=%0d got=%b exp=0", t, move_left); end
    end
  endtask

  task automatic test_both();
    btn_left = 1'b1; btn_right = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if ({move_left, move_right} !== 2'b00)
        begin errors++; $display("FAIL both_held t=%0d got=%b%b exp=00", t, move_left, move_right); end
    end
    btn_right = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if ({move_left, move_right} !== {t >= 7, 1'b0})
        begin errors++; $display("FAIL both_release t=%0d got=%b%b exp=%b0", t, move_left, move_right, t >= 7); end
    end
    btn_left = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_jump();
    int rises;
    logic prev;
    game_active = 1'b1; jump_active = 1'b0;
    wait_phase(3);
    btn_jump = 1'b1;
    // Rise lands at phase 1, request visible at phase 2, consumed by the SCEN at phase 7.
    for (int t = 1; t <= 13; t++) begin
      tick();
      checks++;
      if (jump !== (t >= 7 && t <= 12)) begin errors++; $display("FAIL jump_consume t=%0d got=%b exp=%b", t, jump, (t >= 7 && t <= 12)); end
    end
    rises = 0; prev = jump;
    repeat (40) begin tick(); if (jump && !prev) rises++; prev = jump; end
    checks++;
    if (rises !== 0) begin errors++; $display("FAIL jump_held_retrigger got=%0d exp=0", rises); end
    btn_jump = 1'b0;
    repeat (10) tick();
    btn_jump = 1'b1;
    rises = 0; prev = jump;
    repeat (20) begin tick(); if (jump && !prev) rises++; prev = jump; end
    checks++;
    if (rises !== 1) begin errors++; $display("FAIL jump_repress got=%0d exp=1", rises); end
    btn_jump = 1'b0;
    repeat (10) tick();
    // Falling game_active drops a pending request.
    wait_phase(3);
    btn_jump = 1'b1;
    repeat (8) tick();
    checks++;
    if (jump !== 1'b1) begin errors++; $display("FAIL jump_pre_inactive got=%b exp=1", jump); end
    game_active = 1'b0;
    tick();
    checks++;
    if (jump !== 1'b0) begin errors++; $display("FAIL jump_inactive_clear got=%b exp=0", jump); end
    btn_jump = 1'b0; game_active = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_set_wins();
    wait_phase(1);
    btn_jump = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      checks++;
      if (jump !== (t >= 7 && t <= 14)) begin errors++; $display("FAIL jump_set_wins t=%0d got=%b exp=%b", t, jump, (t >= 7 && t <= 14)); end
    end
    btn_jump = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_airborne();
    jump_active = 1'b1;
    btn_jump = 1'b1;
    for (int t = 1; t <= 35; t++) begin
      tick();
      if (t == 15) jump_active = 1'b0;
      checks++;
      if (jump !== 1'b0) begin errors++; $display("FAIL jump_airborne t=%0d got=%b exp=0", t, jump); end
    end
    btn_jump = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    wait_phase(3);
    btn_jump = 1'b1;
    repeat (9) tick();
    checks++;
    if (jump !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got=%b exp=1", jump); end
    btn_jump = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (outs !== 5'b0) begin errors++; $display("FAIL rst_mid_outs got=%b exp=00000", outs); end
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (SCEN !== (k == 7)) begin errors++; $display("FAIL rst_mid_scen k=%0d got=%b exp=%b", k, SCEN, k == 7); end
    end
  endtask

  task automatic test_random();
    int hold [3];
    int ga_hold, ja_hold;
    for (int b = 0; b < 3; b++) hold[b] = 0;
    ga_hold = 0; ja_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          hold[b] = $urandom_range(1, 9);
          case (b)
            0: btn_left  = $urandom_range(0, 1);
            1: btn_right = $urandom_range(0, 1);
            default: btn_jump = $urandom_range(0, 1);
          endcase
        end
        hold[b]--;
      end
      if (ga_hold == 0) begin ga_hold = $urandom_range(5, 80); game_active = ($urandom_range(0, 4) != 0); end
      ga_hold--;
      if (ja_hold == 0) begin ja_hold = $urandom_range(3, 30); jump_active = ($urandom_range(0, 2) == 0); end
      ja_hold--;
      reset = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (outs !== m_outs()) begin errors++; $display("FAIL random n=%0d got=%b exp=%b", n, outs, m_outs()); end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left();
    test_both();
    test_jump();
    test_set_wins();
    test_airborne();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
